// File: rtl/medidor_ultrassonico_pkg.sv
// Shared types and default timing for the ultrasonic range finder.
package medidor_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      DISPARO,
      ESPERA_ECO,
      MEDE,
      PAUSA
   } estado_t;

   localparam logic [7:0] DIST_MAX = 8'd255;

   localparam int unsigned CICLOS_US_PADRAO  = 50;
   localparam int unsigned TRIG_US_PADRAO    = 10;
   localparam int unsigned CM_US_PADRAO      = 58;
   localparam int unsigned TIMEOUT_US_PADRAO = 30000;
   localparam int unsigned PERIODO_US_PADRAO = 60000;

   function automatic int unsigned maior(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/medidor_ultrassonico_if.sv
// Control/result bundle between the range finder and its sensor/consumers.
interface medidor_ultrassonico_if;
   import medidor_pkg::*;

   logic                         habilita;
   logic                         eco;
   logic                         trig;
   logic [$bits(DIST_MAX)-1:0]   distancia_cm;
   logic                         valido;
   logic                         erro;
   logic                         ocupado;

   modport master (
      output habilita, eco,
      input  trig, distancia_cm, valido, erro, ocupado
   );

   modport slave (
      input  habilita, eco,
      output trig, distancia_cm, valido, erro, ocupado
   );

endinterface

// File: rtl/medidor_ultrassonico_gerador_tick_us.sv
// One-cycle microsecond tick; held cleared while limpa is high.
module gerador_tick_us
   import medidor_pkg::*;
#(
   parameter int unsigned CICLOS_US = CICLOS_US_PADRAO
) (
   input  logic clk,
   input  logic rst_n,
   input  logic limpa,
   output logic tick
);

   localparam int unsigned W = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;

   logic [W-1:0] cnt_q, cnt_d;
   logic         fim;

   assign fim  = (cnt_q == W'(CICLOS_US - 1));
   assign tick = fim & ~limpa;

   // Next divider count: wrap at CICLOS_US-1, hold at zero while cleared
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (limpa || fim) begin
         cnt_d = '0;
      end
   end

   // Divider register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/medidor_ultrassonico.sv
// HC-SR04 front end: periodic trigger, echo timing, centimetre conversion.
// Assumes CM_US >= 2 and TIMEOUT_US >= 2.
module medidor_ultrassonico
   import medidor_pkg::*;
#(
   parameter int unsigned CICLOS_US  = CICLOS_US_PADRAO,
   parameter int unsigned TRIG_US    = TRIG_US_PADRAO,
   parameter int unsigned CM_US      = CM_US_PADRAO,
   parameter int unsigned TIMEOUT_US = TIMEOUT_US_PADRAO,
   parameter int unsigned PERIODO_US = PERIODO_US_PADRAO
) (
   input  logic                    clk,
   input  logic                    rst_n,
   medidor_ultrassonico_if.slave   bus
);

   localparam int unsigned W_US  = $clog2(maior(PERIODO_US, TIMEOUT_US) + 1);
   localparam int unsigned W_SUB = (CM_US > 1) ? $clog2(CM_US) : 1;

   estado_t            estado_q, estado_d;
   logic               eco_meta_q, eco_s_q, eco_ant_q;
   logic [W_US-1:0]    per_q, per_d;
   logic [W_US-1:0]    us_q, us_d;
   logic [W_SUB-1:0]   sub_q, sub_d;
   logic [7:0]         cm_q, cm_d;
   logic [7:0]         dist_q, dist_d;
   logic               erro_q, erro_d;
   logic               valido_q, valido_d;
   logic               tick;
   logic               trig_c, ocupado_c;

   gerador_tick_us #(.CICLOS_US(CICLOS_US)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .limpa (estado_q == OCIOSO),
      .tick  (tick)
   );

   // Two-flop echo synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eco_meta_q <= 1'b0;
         eco_s_q    <= 1'b0;
         eco_ant_q  <= 1'b0;
      end else begin
         eco_meta_q <= bus.eco;
         eco_s_q    <= eco_meta_q;
         eco_ant_q  <= eco_s_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= OCIOSO;
         per_q    <= '0;
         us_q     <= '0;
         sub_q    <= '0;
         cm_q     <= '0;
         dist_q   <= '0;
         erro_q   <= 1'b0;
         valido_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         per_q    <= per_d;
         us_q     <= us_d;
         sub_q    <= sub_d;
         cm_q     <= cm_d;
         dist_q   <= dist_d;
         erro_q   <= erro_d;
         valido_q <= valido_d;
      end
   end

   // Next state and datapath: period/timeout counting, cm conversion, publish
   always_comb begin
      estado_d = estado_q;
      per_d    = tick ? per_q + 1'b1 : per_q;
      us_d     = us_q;
      sub_d    = sub_q;
      cm_d     = cm_q;
      dist_d   = dist_q;
      erro_d   = erro_q;
      valido_d = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (bus.habilita) begin
               estado_d = DISPARO;
               per_d    = '0;
               us_d     = '0;
            end
         end
         DISPARO: begin
            if (tick) begin
               if (us_q == W_US'(TRIG_US - 1)) begin
                  estado_d = ESPERA_ECO;
                  us_d     = '0;
               end else begin
                  us_d = us_q + 1'b1;
               end
            end
         end
         ESPERA_ECO: begin
            if (eco_s_q && !eco_ant_q) begin
               // the edge cycle already carries echo, so its tick is counted here
               estado_d = MEDE;
               cm_d     = '0;
               sub_d    = tick ? W_SUB'(1) : '0;
               us_d     = tick ? W_US'(1) : '0;
            end else if (tick) begin
               if (us_q == W_US'(TIMEOUT_US - 1)) begin
                  estado_d = PAUSA;
                  dist_d   = DIST_MAX;
                  erro_d   = 1'b1;
                  valido_d = 1'b1;
               end else begin
                  us_d = us_q + 1'b1;
               end
            end
         end
         MEDE: begin
            if (!eco_s_q) begin
               estado_d = PAUSA;
               dist_d   = cm_q;
               erro_d   = 1'b0;
               valido_d = 1'b1;
            end else if (tick) begin
               if (us_q == W_US'(TIMEOUT_US - 1)) begin
                  estado_d = PAUSA;
                  dist_d   = DIST_MAX;
                  erro_d   = 1'b1;
                  valido_d = 1'b1;
               end else begin
                  us_d = us_q + 1'b1;
                  if (sub_q == W_SUB'(CM_US - 1)) begin
                     sub_d = '0;
                     if (cm_q != DIST_MAX) begin
                        cm_d = cm_q + 1'b1;
                     end
                  end else begin
                     sub_d = sub_q + 1'b1;
                  end
               end
            end
         end
         PAUSA: begin
            if (tick && (per_q >= W_US'(PERIODO_US - 1))) begin
               if (bus.habilita) begin
                  estado_d = DISPARO;
                  per_d    = '0;
                  us_d     = '0;
               end else begin
                  estado_d = OCIOSO;
               end
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // Moore outputs decoded from the state
   always_comb begin
      trig_c    = (estado_q == DISPARO);
      ocupado_c = (estado_q != OCIOSO);
   end

   assign bus.trig         = trig_c;
   assign bus.ocupado      = ocupado_c;
   assign bus.distancia_cm = dist_q;
   assign bus.erro         = erro_q;
   assign bus.valido       = valido_q;

endmodule

// File: tb/tb_medidor_ultrassonico.sv
// Scoreboard bench for medidor_ultrassonico.
module tb_medidor_ultrassonico;
   import medidor_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } esperado_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ciclo = 0;

   medidor_ultrassonico_if bus();

   medidor_ultrassonico #(
      .CICLOS_US  (1),
      .TRIG_US    (10),
      .CM_US      (58),
      .TIMEOUT_US (30000),
      .PERIODO_US (60001)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Cycle index, read on the falling edge
   always @(posedge clk) ciclo <= ciclo + 1;

   esperado_t fila[$];
   esperado_t x_mon;
   int erros = 0;
   int checagens = 0;
   int n_sobe = 0, n_desce = 0, n_valido = 0;
   int t_sobe = 0, t_desce = 0, t_valido = 0;
   logic       trig_ant = 1'b0;
   logic       valido_ant = 1'b0;
   logic [7:0] dist_ant = 8'd0;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checagens++;
      if (obs !== esp) begin
         erros++;
         $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
      end
   endtask

   function automatic int le_cont(input int qual);
      case (qual)
         0: return n_sobe;
         1: return n_desce;
         default: return n_valido;
      endcase
   endfunction

   // Monitor: edge bookkeeping and scoreboard pop on each valido
   always @(negedge clk) begin
      if (bus.trig && !trig_ant) begin
         n_sobe++;
         t_sobe = ciclo;
      end
      if (!bus.trig && trig_ant) begin
         n_desce++;
         t_desce = ciclo;
      end
      trig_ant = bus.trig;
      if (bus.valido) begin
         n_valido++;
         t_valido = ciclo;
         if (valido_ant) verifica("valido_duplo", 1, 0);
         if (fila.size() == 0) begin
            verifica("valido_extra", 1, 0);
         end else begin
            x_mon = fila.pop_front();
            verifica("distancia", bus.distancia_cm, x_mon.d);
            verifica("erro", bus.erro, x_mon.e);
         end
      end else if (rst_n && bus.distancia_cm != dist_ant) begin
         verifica("dist_sem_valido", bus.distancia_cm, dist_ant);
      end
      valido_ant = bus.valido;
      dist_ant   = bus.distancia_cm;
   end

   task automatic aguarda(input string tag, input int qual, input int alvo, input int limite);
      int n = 0;
      while (le_cont(qual) < alvo && n < limite) begin
         @(negedge clk);
         #1;
         n++;
      end
      verifica({tag, "_prazo"}, (le_cont(qual) >= alvo), 1);
   endtask

   task automatic pulso_eco(input int largura, input logic [7:0] d, input logic e);
      esperado_t x;
      int nv;
      repeat (5) @(posedge clk);
      #1;
      bus.eco = 1'b1;
      x.d = d;
      x.e = e;
      fila.push_back(x);
      nv = n_valido;
      repeat (largura) @(posedge clk);
      #1;
      bus.eco = 1'b0;
      aguarda("valido", 2, nv + 1, 20);
   endtask

   task automatic reinicia();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic dispara();
      int base = n_desce;
      aguarda("trig_desce", 1, base + 1, 100);
   endtask

   initial begin
      int h, base, nv0, t1;
      bus.habilita = 1'b0;
      bus.eco      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      verifica("rst_trig", bus.trig, 0);
      verifica("rst_dist", bus.distancia_cm, 0);
      verifica("rst_valido", bus.valido, 0);
      verifica("rst_erro", bus.erro, 0);
      verifica("rst_ocupado", bus.ocupado, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Trigger timing from habilita, then 580 us echo
      @(posedge clk);
      #1;
      bus.habilita = 1'b1;
      h = ciclo;
      aguarda("trig_sobe", 0, 1, 20);
      verifica("trig_atraso", t_sobe - h, 1);
      verifica("ocupado", bus.ocupado, 1);
      dispara();
      verifica("trig_largura", t_desce - t_sobe, 10);
      pulso_eco(580, 8'd10, 1'b0);

      // 1160 us echo
      reinicia();
      dispara();
      pulso_eco(1160, 8'd20, 1'b0);

      // Reset in the middle of the trigger pulse, then 579 us echo
      base = n_sobe;
      reinicia();
      aguarda("trig_sobe2", 0, base + 1, 20);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      verifica("trig_reset", bus.trig, 0);
      verifica("dist_reset", bus.distancia_cm, 0);
      verifica("ocupado_reset", bus.ocupado, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dispara();
      pulso_eco(579, 8'd9, 1'b0);

      // Over-range echo with a proper falling edge
      reinicia();
      dispara();
      nv0 = n_valido;
      pulso_eco(17400, 8'd255, 1'b0);
      repeat (20) @(negedge clk);
      verifica("valido_unico", n_valido - nv0, 1);

      // Echo already high across the trigger must be ignored
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      bus.eco = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dispara();
      repeat (20) @(posedge clk);
      #1;
      bus.eco = 1'b0;
      repeat (20) @(posedge clk);
      pulso_eco(1160, 8'd20, 1'b0);

      // No echo: timeout report and trigger period
      reinicia();
      dispara();
      t1 = t_sobe;
      fila.push_back('{d: 8'd255, e: 1'b1});
      aguarda("timeout", 2, n_valido + 1, 30100);
      verifica("timeout_latencia", t_valido - t_desce, 30000);
      base = n_sobe;
      aguarda("trig_periodo", 0, base + 1, 31000);
      verifica("periodo", t_sobe - t1, 60001);

      // Reset during MEDE with habilita low afterwards
      dispara();
      repeat (5) @(posedge clk);
      #1;
      bus.eco = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      verifica("erro_mantido", bus.erro, 1);
      verifica("dist_mantida", bus.distancia_cm, 255);
      nv0 = n_valido;
      rst_n        = 1'b0;
      bus.habilita = 1'b0;
      bus.eco      = 1'b0;
      #1;
      verifica("trig_reset_mede", bus.trig, 0);
      verifica("dist_reset_mede", bus.distancia_cm, 0);
      verifica("erro_reset_mede", bus.erro, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      #1;
      verifica("ocioso_ocupado", bus.ocupado, 0);
      verifica("ocioso_trig", bus.trig, 0);
      verifica("sem_valido_abortado", n_valido - nv0, 0);
      verifica("fila_vazia", fila.size(), 0);

      $display("Result: errors=%0d of %0d checks", erros, checagens);
      $finish;
   end

endmodule
